// File: rtl/fp_pkg.sv
// Shared types and defaults for the FP normalizer.
// Holds default widths, the state enum and the packed float layout.
package fp_pkg;

  localparam int MANT_W_D = 24;
  localparam int EXP_W_D  = 8;

  localparam logic [EXP_W_D-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_D-1:0]    exp;
    logic [MANT_W_D-2:0]   frac;
  } fp_word_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle between the ALU, normalizer and consumer.
// The slave side is the normalizer; the master side is the environment.
interface fp_normalizer_if
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_D,
  parameter int EXP_W  = EXP_W_D
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [MANT_W-1:0]       aligned_result;
  logic                    carry_out;
  logic                    aligned_sign;
  logic [EXP_W-1:0]        exponent_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W-1:0] result;
  logic                    overflow;
  logic [4:0]              shift_count;

  modport slave (
    input  in_valid, aligned_result, carry_out,
    input  aligned_sign, exponent_in, out_ready,
    output in_ready, out_valid, result,
    output overflow, shift_count
  );

  modport master (
    output in_valid, aligned_result, carry_out,
    output aligned_sign, exponent_in, out_ready,
    input  in_ready, out_valid, result,
    input  overflow, shift_count
  );

endinterface

// File: rtl/fp_pack.sv
// Combinational packer: exponent select and IEEE field concatenation.
// A clear hidden bit always packs as exponent 0 (denormal or zero).
module fp_pack
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_D,
  parameter int EXP_W  = EXP_W_D
) (
  input  logic                    sign,
  input  logic [EXP_W-1:0]        exp,
  input  logic [MANT_W-1:0]       mant,
  input  logic                    ovf,
  output logic [EXP_W+MANT_W-1:0] word
);

  logic [EXP_W-1:0] exp_sel;

  always_comb begin
    exp_sel = '0;
    if (mant[MANT_W-1]) begin
      exp_sel = (exp == '0) ? EXP_W'(1) : exp;
    end
  end

  always_comb begin
    word = '0;
    if (ovf) begin
      word = {sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
    end else begin
      word = {sign, exp_sel, mant[MANT_W-2:0]};
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Post-ALU normalizer: carry fix-up, left-shift normalize, pack.
// One result in flight; a new operand is taken only in IDLE.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_D,
  parameter int EXP_W  = EXP_W_D
) (
  input logic             clk,
  input logic             rst_n,
  fp_normalizer_if.slave  bus
);

  localparam logic [EXP_W-1:0] ONES = '1;

  state_t            state;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  exp_q;
  logic              sign_q;
  logic              ovf_q;
  logic [4:0]        sc_q;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.overflow    = ovf_q;
  assign bus.shift_count = sc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mant   <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      sc_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sc_q   <= '0;
            ovf_q  <= 1'b0;
            sign_q <= bus.aligned_sign;
            mant   <= bus.aligned_result;
            exp_q  <= bus.exponent_in;
            state  <= NORM;
            if (bus.carry_out) begin
              mant  <= {1'b1,
                        bus.aligned_result[MANT_W-1:1]};
              exp_q <= bus.exponent_in + 1'b1;
              ovf_q <= (bus.exponent_in >= ONES - 1'b1);
              state <= DONE;
            end else if (bus.aligned_result == '0) begin
              exp_q  <= '0;
              sign_q <= 1'b0;
              state  <= DONE;
            end else if (bus.exponent_in == '0) begin
              state <= DONE;
            end
          end
        end
        NORM: begin
          // exp==1 with no hidden bit stops as a denormal
          if (mant[MANT_W-1] || exp_q == EXP_W'(1)) begin
            state <= DONE;
          end else begin
            mant  <= mant << 1;
            exp_q <= exp_q - 1'b1;
            sc_q  <= sc_q + 5'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fp_pack #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_pack (
    .sign (sign_q),
    .exp  (exp_q),
    .mant (mant),
    .ovf  (ovf_q),
    .word (bus.result)
  );

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: latency, packing, stall, reset.
// Expected words are hand-computed IEEE-754 single values.
module tb_fp_normalizer;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_normalizer_if #(.MANT_W(24), .EXP_W(8)) bus ();

  fp_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [23:0] ar;
    logic        c;
    logic        s;
    logic [7:0]  e;
    logic [31:0] res;
    logic        ov;
    logic [4:0]  sc;
    int          lat;
    int          stall;
  } vec_t;

  vec_t v[10] = '{
    '{24'h000000, 1'b1, 1'b0, 8'h7F, 32'h40000000, 1'b0, 5'd0,  1, 0},
    '{24'h000001, 1'b0, 1'b1, 8'h7F, 32'hB4000000, 1'b0, 5'd23, 25, 0},
    '{24'h000000, 1'b0, 1'b1, 8'h55, 32'h00000000, 1'b0, 5'd0,  1, 0},
    '{24'h000000, 1'b1, 1'b0, 8'hFE, 32'h7F800000, 1'b1, 5'd0,  1, 0},
    '{24'h000010, 1'b0, 1'b0, 8'h03, 32'h00000040, 1'b0, 5'd2,  4, 5},
    '{24'h800001, 1'b0, 1'b1, 8'h00, 32'h80800001, 1'b0, 5'd0,  1, 0},
    '{24'h000100, 1'b0, 1'b0, 8'h00, 32'h00000100, 1'b0, 5'd0,  1, 0},
    '{24'h400000, 1'b0, 1'b0, 8'h80, 32'h3F800000, 1'b0, 5'd1,  3, 0},
    '{24'hFFFFFF, 1'b1, 1'b1, 8'h10, 32'h88FFFFFF, 1'b0, 5'd0,  1, 0},
    '{24'h800000, 1'b0, 1'b0, 8'h7F, 32'h3F800000, 1'b0, 5'd0,  2, 0}
  };

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_ov"},  64'(bus.out_valid), 64'd0);
    chk({tag, "_res"}, 64'(bus.result), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_sc"},  64'(bus.shift_count), 64'd0);
  endtask

  task automatic capture(input vec_t t);
    @(negedge clk);
    bus.aligned_result = t.ar;
    bus.carry_out      = t.c;
    bus.aligned_sign   = t.s;
    bus.exponent_in    = t.e;
    bus.in_valid       = 1'b1;
    @(posedge clk);
    #1;
    // keep offering junk to prove it is ignored
    bus.aligned_result = ~t.ar;
    bus.carry_out      = ~t.c;
    bus.aligned_sign   = ~t.s;
    bus.exponent_in    = 8'h01;
  endtask

  task automatic run_op(input int idx, input vec_t t);
    string tag;
    int cyc;
    tag = $sformatf("v%0d", idx);
    capture(t);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(cyc + 1), 64'(t.lat));
    chk({tag, "_res"}, 64'(bus.result), 64'(t.res));
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(t.ov));
    chk({tag, "_sc"},  64'(bus.shift_count), 64'(t.sc));
    for (int i = 0; i < t.stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_ov"},  64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_hold_res"}, 64'(bus.result), 64'(t.res));
      chk({tag, "_hold_sc"},  64'(bus.shift_count), 64'(t.sc));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_ov_after"},  64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.aligned_result = '0;
    bus.carry_out      = 1'b0;
    bus.aligned_sign   = 1'b0;
    bus.exponent_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("post_rst");

    for (int i = 0; i < 10; i++) run_op(i, v[i]);

    capture(v[1]);
    repeat (5) @(posedge clk);
    #2;
    chk("mid_ov", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("mid_rel");
    seen = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    chk("mid_no_ov", 64'(seen), 64'd0);

    run_op(20, v[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter MANT_W, default 24, aligned mantissa width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, ALU result present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a result.
REQ-007 SHALL have port aligned_result, input, MANT_W, ALU magnitude.
REQ-008 SHALL have port carry_out, input, 1, ALU carry.
REQ-009 SHALL have port aligned_sign, input, 1, result sign.
REQ-010 SHALL have port exponent_in, input, EXP_W, biased exponent of the larger operand.
REQ-011 SHALL have port out_valid, output, 1, packed result available.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port result, output, 1+EXP_W+MANT_W-1, IEEE-754 word {sign, exp, frac}.
REQ-014 SHALL have port overflow, output, 1, result saturated to infinity.
REQ-015 SHALL have port shift_count, output, 5, number of left shifts applied.

Function
REQ-016 SHALL implement the FSM IDLE -> NORM -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 SHALL capture the inputs into internal mant/exp/sign registers on in_valid&&in_ready (edge T), and SHALL clear shift_count and overflow.
REQ-018 On capture with carry_out=1: SHALL set mant = {1, aligned_result[MANT_W-1:1]} and exp = exponent_in+1, then go to DONE; if exp+1 == all-ones, SHALL set overflow=1 and result = {sign, all-ones, 0}.
REQ-019 On capture with carry_out=0 and aligned_result=0: SHALL go to DONE with result = all-zero (+0, sign forced to 0).
REQ-020 On capture with exponent_in=0 (denormal operands, no carry): SHALL go to DONE unshifted; the packed exponent is 1 if mant MSB is set, else 0.
REQ-021 Otherwise SHALL go to NORM.
REQ-022 In NORM, each cycle: if mant MSB=1 -> DONE; else if exp==1 -> DONE as a denormal (packed exponent 0); else mant<<=1, exp-=1, shift_count+=1.
REQ-023 SHALL reach out_valid at T+1 for the REQ-018/019/020 cases and at T+k+2 for the NORM case, where k is the number of shifts; maximum k = MANT_W-1.
REQ-024 SHALL pack result = {sign, exp, mant[MANT_W-2:0]}, with truncation and no rounding.
REQ-025 SHALL hold result, overflow and shift_count stable while out_valid=1 && out_ready=0.
REQ-026 On out_valid&&out_ready SHALL return to IDLE; in_ready SHALL be 1 in the following cycle, with no same-cycle accept/issue overlap.
REQ-027 SHALL ignore in_valid outside IDLE.

Reset
REQ-028 While rst_n=0: SHALL set state=IDLE and clear result, overflow, shift_count and the internal registers to 0; out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-029 Reset asserted mid-NORM or in DONE SHALL discard the operation with no output handshake.

Structure
REQ-030 Package fp_pkg SHALL hold MANT_W/EXP_W defaults, the exponent all-ones constant, the FSM state enum and a packed-float struct typedef.
REQ-031 Packing (REQ-020/022/024 exponent select and field concatenation) SHALL be one combinational sub-module, fp_pack.

Verification
REQ-032 carry_out=1, aligned_result=0x000000, exponent_in=0x7F, sign 0 -> result=0x40000000, out_valid at T+1, shift_count=0.
REQ-033 aligned_result=0x000001, carry 0, exponent_in=0x7F, sign 1 -> result=0xB4000000, shift_count=23, out_valid at T+25.
REQ-034 aligned_result=0, carry 0, sign 1 -> result=0x00000000 at T+1, overflow=0.
REQ-035 carry_out=1, exponent_in=0xFE, aligned_result=0, sign 0 -> result=0x7F800000, overflow=1.
REQ-036 aligned_result=0x000010, exponent_in=0x03, sign 0 -> result=0x00000040 (denormal), shift_count=2, out_valid at T+4.
REQ-037 out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0; then rst_n pulsed low mid-NORM on the next operation -> next cycle IDLE, all outputs 0, no out_valid.
